// File: rtl/matrix_rx_pkg.sv
// matrix_rx_pkg: shared types for the matrix stream receiver.
// Holds the receiver state encoding, the per-element header carried
// through the FIFO, and a helper that sizes a full FIFO entry for a
// given row/column index width.
package matrix_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Element byte plus its boundary flags; row/col indices follow it in an entry
   typedef struct packed {
      logic [7:0] data;
      logic       row_last;
      logic       frame_last;
   } elem_hdr_t;

   localparam int HDR_W = $bits(elem_hdr_t);

   // Entry = {hdr, row, col}
   function automatic int entry_w(input int idx_w);
      return HDR_W + 2 * idx_w;
   endfunction

endpackage

// File: rtl/matrix_rx_fifo.sv
// matrix_rx_fifo: single-clock FIFO for matrix elements.
// Besides push/pop it can set the row_last/frame_last bits of the newest
// stored entry, and it exposes a look-ahead of the head and count as they
// will be after the current cycle so the consumer side can register them.
module matrix_rx_fifo #(
   parameter int W      = 26,
   parameter int DEPTH  = 64,
   parameter int RL_BIT = 17,
   parameter int FL_BIT = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [W-1:0]             i_wdata,
   input  logic                     i_pop,
   input  logic                     i_set_rl,
   input  logic                     i_set_fl,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count_nxt,
   output logic [W-1:0]             o_head_nxt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;

   logic          w_push;
   logic          w_pop;
   logic          w_mark;
   logic [AW-1:0] w_newest;
   logic [AW-1:0] w_rptr_nxt;

   assign o_full     = (r_count == FULL_CNT);
   assign w_push     = i_push && !o_full;
   assign w_pop      = i_pop && (r_count != '0);
   assign w_mark     = (i_set_rl || i_set_fl) && !w_push && (r_count != '0);
   assign w_newest   = r_wptr - 1'b1;
   assign w_rptr_nxt = w_pop ? r_rptr + 1'b1 : r_rptr;

   // Occupancy after this cycle's push/pop
   always_comb begin
      o_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   o_count_nxt = r_count + 1'b1;
         2'b01:   o_count_nxt = r_count - 1'b1;
         default: o_count_nxt = r_count;
      endcase
   end

   // Head as it will read after this cycle, including a same-cycle flag rewrite
   always_comb begin
      o_head_nxt = r_mem[w_rptr_nxt];
      if (w_push && (w_rptr_nxt == r_wptr))
         o_head_nxt = i_wdata;
      if (w_mark && (w_rptr_nxt == w_newest)) begin
         if (i_set_rl) o_head_nxt[RL_BIT] = 1'b1;
         if (i_set_fl) o_head_nxt[FL_BIT] = 1'b1;
      end
   end

   // Storage: element writes and flag rewrites of the newest entry
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= i_wdata;
      if (w_mark && i_set_rl)
         r_mem[w_newest][RL_BIT] <= 1'b1;
      if (w_mark && i_set_fl)
         r_mem[w_newest][FL_BIT] <= 1'b1;
   end

   // Pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         r_rptr  <= w_rptr_nxt;
         r_count <= o_count_nxt;
      end
   end

endmodule

// File: rtl/matrix_stream_rx.sv
// matrix_stream_rx: receive side of the CPU matrix output stream.
// Buffers one frame of element bytes, tags each with row/col indices and
// row/frame boundary flags, and hands them to a valid/ack byte consumer.
// The newest element is held back while receiving so end-of-row/frame
// markers can still be attached to it.
// Optional build macro: MATRIX_RX_SHAPE_CHECK_EN (flags ragged rows and
// frames that end in an unterminated row through err).
module matrix_stream_rx
   import matrix_rx_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [7:0]       out_matrix,
   input  logic             out_matrix_en,
   input  logic             out_matrix_end_row,
   input  logic             out_matrix_end,
   input  logic [7:0]       out_matrix_position,
   input  logic             out_matrix_position_en,
   output logic [7:0]       rx_byte,
   output logic             rx_byte_en,
   input  logic             rx_byte_ack,
   output logic             rx_row_last,
   output logic             rx_last,
   output logic [IDX_W-1:0] rx_row,
   output logic [IDX_W-1:0] rx_col,
   output logic [7:0]       rx_position,
   output logic             busy,
   output logic             err
);

   localparam int EW     = entry_w(IDX_W);
   localparam int AW     = $clog2(DEPTH);
   localparam int FL_BIT = 2 * IDX_W;
   localparam int RL_BIT = 2 * IDX_W + 1;

   typedef struct packed {
      elem_hdr_t        hdr;
      logic [IDX_W-1:0] row;
      logic [IDX_W-1:0] col;
   } entry_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_row_cnt;
   logic [IDX_W-1:0] r_col_cnt;
   logic             r_row_open;
   logic             r_err;
   logic [7:0]       r_position;
   entry_t           r_out;
   logic             r_vld;

   logic             w_full;
   logic [AW:0]      w_count_nxt;
   logic [EW-1:0]    w_head_nxt;
   logic             w_push;
   logic             w_pop;
   logic             w_end_row_ok;
   logic             w_end_ok;
   logic             w_set_rl;
   logic             w_set_fl;
   logic             w_vld_nxt;
   logic             w_err_set;
   logic             w_shape_err;
   logic [IDX_W-1:0] w_col_after;
   entry_t           w_wdata;

   assign w_pop        = r_vld && rx_byte_ack;
   assign w_push       = out_matrix_en && (r_state != ST_DRAIN) && !w_full;
   assign w_end_row_ok = out_matrix_end_row && (r_state == ST_RECV) && (r_row_open || w_push);
   assign w_end_ok     = out_matrix_end && (r_state == ST_RECV);
   assign w_set_rl     = w_end_row_ok || w_end_ok;
   assign w_set_fl     = w_end_ok;
   assign w_col_after  = r_col_cnt + {{(IDX_W-1){1'b0}}, w_push};

   // Entering or staying in DRAIN presents any entry; RECV withholds the newest one
   assign w_vld_nxt = ((r_state == ST_DRAIN) || w_end_ok) ? (w_count_nxt != '0)
                    : ((r_state == ST_RECV) && (w_count_nxt >= (AW+1)'(2)));

   assign w_err_set = (out_matrix_en && ((r_state == ST_DRAIN) || w_full))
                    || (out_matrix_end_row && !w_end_row_ok)
                    || (out_matrix_position_en && (r_state != ST_IDLE))
                    || w_shape_err;

   // New entry; a marker arriving with its element is folded in directly
   always_comb begin
      w_wdata                = '0;
      w_wdata.hdr.data       = out_matrix;
      w_wdata.hdr.row_last   = w_set_rl;
      w_wdata.hdr.frame_last = w_set_fl;
      w_wdata.row            = r_row_cnt;
      w_wdata.col            = r_col_cnt;
   end

   matrix_rx_fifo #(
      .W      (EW),
      .DEPTH  (DEPTH),
      .RL_BIT (RL_BIT),
      .FL_BIT (FL_BIT)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (resetn),
      .i_push      (w_push),
      .i_wdata     (w_wdata),
      .i_pop       (w_pop),
      .i_set_rl    (w_set_rl && !w_push),
      .i_set_fl    (w_set_fl && !w_push),
      .o_full      (w_full),
      .o_count_nxt (w_count_nxt),
      .o_head_nxt  (w_head_nxt)
   );

`ifdef MATRIX_RX_SHAPE_CHECK_EN
   logic [IDX_W-1:0] r_first_len;
   logic             r_len_valid;

   assign w_shape_err = (w_end_row_ok && r_len_valid && (w_col_after != r_first_len))
                      || (w_end_ok && !w_end_row_ok && (r_row_open || w_push));

   // Remember the first row's length of each frame
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_first_len <= '0;
         r_len_valid <= 1'b0;
      end else if (w_end_ok) begin
         r_len_valid <= 1'b0;
      end else if (w_end_row_ok && !r_len_valid) begin
         r_first_len <= w_col_after;
         r_len_valid <= 1'b1;
      end
   end
`else
   assign w_shape_err = 1'b0;
`endif

   // Frame FSM, element indexing, error/position capture and registered head
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ST_IDLE;
         r_row_cnt  <= '0;
         r_col_cnt  <= '0;
         r_row_open <= 1'b0;
         r_err      <= 1'b0;
         r_position <= '0;
         r_out      <= '0;
         r_vld      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE:  if (w_push) r_state <= ST_RECV;
            ST_RECV:  if (w_end_ok) r_state <= ST_DRAIN;
            ST_DRAIN: if (w_pop && r_out.hdr.frame_last) r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase

         if (w_end_ok) begin
            r_row_cnt <= '0;
            r_col_cnt <= '0;
         end else if (w_end_row_ok) begin
            r_row_cnt <= r_row_cnt + 1'b1;
            r_col_cnt <= '0;
         end else if (w_push) begin
            r_col_cnt <= r_col_cnt + 1'b1;
         end

         if (w_end_ok || w_end_row_ok) r_row_open <= 1'b0;
         else if (w_push)              r_row_open <= 1'b1;

         if (w_err_set) r_err <= 1'b1;

         if (out_matrix_position_en && (r_state == ST_IDLE))
            r_position <= out_matrix_position;

         r_vld <= w_vld_nxt;
         if (w_vld_nxt) r_out <= w_head_nxt;
      end
   end

   assign rx_byte     = r_out.hdr.data;
   assign rx_row_last = r_out.hdr.row_last;
   assign rx_last     = r_out.hdr.frame_last;
   assign rx_row      = r_out.row;
   assign rx_col      = r_out.col;
   assign rx_byte_en  = r_vld;
   assign rx_position = r_position;
   assign busy        = (r_state != ST_IDLE);
   assign err         = r_err;

endmodule

// File: tb/tb_matrix_stream_rx.sv
// tb_matrix_stream_rx: directed bench for matrix_stream_rx.
// Inputs change 1 time unit after the rising edge; delivered elements are
// captured on the falling edge whenever rx_byte_en && rx_byte_ack.
module tb_matrix_stream_rx;

   localparam int DEPTH = 64;
   localparam int IDX_W = 8;
`ifdef MATRIX_RX_SHAPE_CHECK_EN
   localparam logic SHAPE_ERR_EXP = 1'b1;
`else
   localparam logic SHAPE_ERR_EXP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic [7:0]       out_matrix = '0;
   logic             out_matrix_en = 1'b0;
   logic             out_matrix_end_row = 1'b0;
   logic             out_matrix_end = 1'b0;
   logic [7:0]       out_matrix_position = '0;
   logic             out_matrix_position_en = 1'b0;
   logic [7:0]       rx_byte;
   logic             rx_byte_en;
   logic             rx_byte_ack = 1'b0;
   logic             rx_row_last;
   logic             rx_last;
   logic [IDX_W-1:0] rx_row;
   logic [IDX_W-1:0] rx_col;
   logic [7:0]       rx_position;
   logic             busy;
   logic             err;

   typedef struct packed {
      logic [7:0]       b;
      logic             rl;
      logic             l;
      logic [IDX_W-1:0] r;
      logic [IDX_W-1:0] c;
   } rec_t;

   rec_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   matrix_stream_rx #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clk                    (clk),
      .resetn                 (resetn),
      .out_matrix             (out_matrix),
      .out_matrix_en          (out_matrix_en),
      .out_matrix_end_row     (out_matrix_end_row),
      .out_matrix_end         (out_matrix_end),
      .out_matrix_position    (out_matrix_position),
      .out_matrix_position_en (out_matrix_position_en),
      .rx_byte                (rx_byte),
      .rx_byte_en             (rx_byte_en),
      .rx_byte_ack            (rx_byte_ack),
      .rx_row_last            (rx_row_last),
      .rx_last                (rx_last),
      .rx_row                 (rx_row),
      .rx_col                 (rx_col),
      .rx_position            (rx_position),
      .busy                   (busy),
      .err                    (err)
   );

   always #5 clk = ~clk;

   // Capture each element the consumer accepts
   always @(negedge clk) begin
      if (resetn && rx_byte_en && rx_byte_ack)
         q.push_back('{b: rx_byte, rl: rx_row_last, l: rx_last, r: rx_row, c: rx_col});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      out_matrix    = b;
      out_matrix_en = 1'b1;
      tick();
      out_matrix_en = 1'b0;
   endtask

   task automatic end_row();
      out_matrix_end_row = 1'b1;
      tick();
      out_matrix_end_row = 1'b0;
   endtask

   task automatic end_frame();
      out_matrix_end = 1'b1;
      tick();
      out_matrix_end = 1'b0;
   endtask

   task automatic set_pos(input logic [7:0] p);
      out_matrix_position    = p;
      out_matrix_position_en = 1'b1;
      tick();
      out_matrix_position_en = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      repeat (2) tick();
      resetn = 1'b1;
      tick();
      q.delete();
   endtask

   // Bounded wait for the frame to drain; an expired bound is a failed check
   task automatic wait_idle(input string tag, input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (!busy && !rx_byte_en) break;
         tick();
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      int bad;

      // Reset state
      tick();
      tick();
      chk("rst_en", 32'(rx_byte_en), 32'd0);
      chk("rst_byte", 32'(rx_byte), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_pos", 32'(rx_position), 32'd0);
      chk("rst_rowcol", 32'({rx_row, rx_col, rx_row_last, rx_last}), 32'd0);
      resetn = 1'b1;
      tick();

      // 2x3 frame with position, ack held high
      set_pos(8'h25);
      rx_byte_ack = 1'b1;
      push(8'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      push(8'd2); push(8'd3); end_row();
      push(8'd4); push(8'd5); push(8'd6); end_row();
      end_frame();
      wait_idle("t1_drain", 20);
      chk("t1_count", 32'(q.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t1_byte%0d", i), 32'(q[i].b), 32'(i + 1));
         chk($sformatf("t1_row%0d", i), 32'(q[i].r), 32'(i / 3));
         chk($sformatf("t1_col%0d", i), 32'(q[i].c), 32'(i % 3));
         chk($sformatf("t1_rl%0d", i), 32'(q[i].rl), 32'((i == 2) || (i == 5)));
         chk($sformatf("t1_last%0d", i), 32'(q[i].l), 32'(i == 5));
      end
      chk("t1_pos", 32'(rx_position), 32'h25);
      chk("t1_err", 32'(err), 32'd0);

      // Position write while receiving is rejected
      q.delete();
      push(8'd7);
      set_pos(8'h11);
      chk("t2_pos", 32'(rx_position), 32'h25);
      chk("t2_err", 32'(err), 32'd1);
      end_frame();
      wait_idle("t2_drain", 20);
      chk("t2_count", 32'(q.size()), 32'd1);
      chk("t2_elem", 32'({q[0].b, q[0].rl, q[0].l}), 32'({8'd7, 1'b1, 1'b1}));

      // Hold-back and output hold with ack low
      do_reset();
      rx_byte_ack = 1'b0;
      push(8'd10); push(8'd11); push(8'd12);
      chk("t3_en", 32'(rx_byte_en), 32'd1);
      chk("t3_head", 32'(rx_byte), 32'd10);
      repeat (3) tick();
      chk("t3_hold", 32'({rx_byte_en, rx_byte, rx_row, rx_col}), 32'({1'b1, 8'd10, 8'd0, 8'd0}));
      rx_byte_ack = 1'b1;
      repeat (5) tick();
      chk("t3_withheld_cnt", 32'(q.size()), 32'd2);
      chk("t3_withheld_en", 32'(rx_byte_en), 32'd0);
      chk("t3_first_two", 32'({q[0].b, q[1].b}), 32'({8'd10, 8'd11}));
      end_row();
      end_frame();
      wait_idle("t3_drain", 20);
      chk("t3_count", 32'(q.size()), 32'd3);
      chk("t3_third", 32'({q[2].b, q[2].rl, q[2].l, q[2].c}), 32'({8'd12, 1'b1, 1'b1, 8'd2}));
      chk("t3_err", 32'(err), 32'd0);

      // Overflow: DEPTH+2 pushes without ack
      do_reset();
      rx_byte_ack = 1'b0;
      for (int i = 1; i <= DEPTH; i++) push(8'(i));
      chk("t4_err_at_full", 32'(err), 32'd0);
      push(8'(DEPTH + 1));
      push(8'(DEPTH + 2));
      chk("t4_err_ovf", 32'(err), 32'd1);
      chk("t4_head", 32'({rx_byte_en, rx_byte}), 32'({1'b1, 8'd1}));
      end_row();
      end_frame();
      rx_byte_ack = 1'b1;
      wait_idle("t4_drain", 200);
      chk("t4_count", 32'(q.size()), 32'(DEPTH));
      bad = 0;
      foreach (q[i]) if (q[i].b != 8'(i + 1)) bad++;
      chk("t4_order", 32'(bad), 32'd0);
      chk("t4_tail", 32'({q[DEPTH-1].l, q[DEPTH-1].c}), 32'({1'b1, 8'(DEPTH - 1)}));

      // Ragged rows: 3 then 2 elements
      do_reset();
      push(8'd1); push(8'd2); push(8'd3); end_row();
      push(8'd4); push(8'd5); end_row();
      chk("t5_shape_err", 32'(err), 32'(SHAPE_ERR_EXP));
      end_frame();
      wait_idle("t5_drain", 20);
      chk("t5_count", 32'(q.size()), 32'd5);
      chk("t5_tail", 32'({q[4].b, q[4].r, q[4].c, q[4].l}), 32'({8'd5, 8'd1, 8'd1, 1'b1}));

      // Reset in the middle of DRAIN, then a fresh 1x1 frame
      do_reset();
      rx_byte_ack = 1'b0;
      push(8'hA1); push(8'hA2); push(8'hA3); end_row(); end_frame();
      chk("t6_draining", 32'({busy, rx_byte_en}), 32'({1'b1, 1'b1}));
      #2;
      resetn = 1'b0;
      #1;
      chk("t6_async_en", 32'(rx_byte_en), 32'd0);
      chk("t6_async_busy", 32'(busy), 32'd0);
      tick();
      resetn = 1'b1;
      tick();
      q.delete();
      rx_byte_ack = 1'b1;
      push(8'h5A); end_row(); end_frame();
      wait_idle("t6_drain", 20);
      chk("t6_count", 32'(q.size()), 32'd1);
      chk("t6_elem", 32'({q[0].b, q[0].r, q[0].c, q[0].rl, q[0].l}),
          32'({8'h5A, 8'd0, 8'd0, 1'b1, 1'b1}));
      chk("t6_err", 32'(err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/matrix_stream_rx.md
Name: matrix_stream_rx

Overview:
Receive end of the processor's memory-mapped matrix output stream: element byte pulses, end-of-row, end-of-matrix and destination-position writes. Buffers one matrix frame in an element FIFO and tags each element with row-last/frame-last flags and row/col indices. Delivers elements to a consumer over a valid/ack byte interface. Sits between the CPU system's matrix outputs and the next node's byte input.

Parameters:
DEPTH, 64, FIFO entries (power of two, >=4)
IDX_W, 8, width of row/column index and count outputs

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
out_matrix  in  8  element byte from CPU
out_matrix_en  in  1  one-cycle strobe: push out_matrix
out_matrix_end_row  in  1  one-cycle strobe: last pushed element ends its row
out_matrix_end  in  1  one-cycle strobe: frame complete
out_matrix_position  in  8  destination position byte
out_matrix_position_en  in  1  one-cycle strobe: latch position
rx_byte  out  8  head element
rx_byte_en  out  1  rx_byte valid
rx_byte_ack  in  1  consumer pops head when rx_byte_en && rx_byte_ack
rx_row_last  out  1  head element ends a row
rx_last  out  1  head element ends the frame
rx_row  out  IDX_W  head element row index
rx_col  out  IDX_W  head element column index
rx_position  out  8  position latched for current frame
busy  out  1  high in RECV or DRAIN
err  out  1  sticky error; cleared only by reset

Behaviour:
- Reset (async, resetn=0): state IDLE, FIFO empty, all outputs 0, position 0, row/col counters 0, err 0.
- FIFO entry = {data[7:0], row_last, frame_last, row[IDX_W-1:0], col[IDX_W-1:0]}.
- States: IDLE -> RECV on first out_matrix_en; RECV -> DRAIN on out_matrix_end; DRAIN -> IDLE on the cycle the frame_last entry is popped.
- Push: out_matrix_en in IDLE/RECV with FIFO not full writes entry {byte, 0, 0, row_cnt, col_cnt}; col_cnt++ (wraps at 2^IDX_W). Full: byte dropped, err<=1. out_matrix_en in DRAIN: dropped, err<=1.
- out_matrix_end_row in RECV: sets row_last on newest entry; row_cnt++, col_cnt<=0. In IDLE or with no element pushed since the last end_row: ignored, err<=1.
- out_matrix_end in RECV: sets frame_last (and row_last) on newest entry; row_cnt/col_cnt <= 0. In IDLE/DRAIN: ignored, no error.
- Hold-back: in RECV the newest entry is never presented (markers may still modify it); rx_byte_en = count>=2 in RECV, count>=1 in DRAIN.
- Output registered from FIFO head; rx_byte_en rises 1 cycle after the enabling condition. Pop on valid&&ack; the next head is valid the following cycle (one element per 2 cycles max when the FIFO holds a single presentable entry, back-to-back otherwise).
- Simultaneous end_row and end in one cycle: both apply. Push and pop in one cycle: count unchanged.
- out_matrix_position_en: latched into rx_position in IDLE only; in RECV/DRAIN ignored, err<=1.
- rx_* outputs hold their values while rx_byte_en=1 and ack=0.
- Reset mid-frame: FIFO and counters flushed, frame discarded.

Optional Feature:
MATRIX_RX_SHAPE_CHECK_EN: when defined, record the column count of the first row of each frame; any later row ending with a different count, or a frame ending with a partial (unterminated) row, sets err. When undefined, ragged rows are accepted silently; err covers overflow/protocol errors only.

Decomposition:
- Package matrix_rx_pkg: state enum (IDLE, RECV, DRAIN), FIFO entry struct, entry width constant.
- Sub-module matrix_rx_fifo: synchronous FIFO with count, plus a port to rewrite the flag bits of the newest entry.

Test Plan:
- 2x3 matrix {1..6} with end_row after 3 and 6, then end, ack held high -> bytes 1..6; rx_row/rx_col (0,0)..(1,2); row_last on 3 and 6; rx_last on 6 only; busy drops after pop of 6; err=0.
- Position 0x25 in IDLE then frame -> rx_position=0x25 throughout; position 0x11 mid-frame -> ignored, err=1.
- Push 3 elements, ack low -> rx_byte_en high with count>=2, element 3 withheld until end; after end all 3 delivered.
- DEPTH+2 pushes with no ack -> DEPTH stored, err=1, the 2 excess bytes never delivered.
- Rows of 3 then 2 elements: with MATRIX_RX_SHAPE_CHECK_EN -> err=1 at the second end_row; without it -> err=0.
- resetn low in mid-DRAIN -> rx_byte_en=0 immediately, state IDLE, a new 1x1 frame is delivered correctly.
